// File: rtl/relu_vec_pkg.sv
// Shared types and float32 constants for the vector activation pipeline.
package relu_vec_pkg;

  typedef logic [31:0] float32_t;

  typedef enum logic [1:0] {
    ACT_PASS  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_CLIP  = 2'd3
  } act_mode_e;

  localparam float32_t   FP_QNAN     = 32'h7FC00000;
  localparam float32_t   FP_POS_ZERO = 32'h00000000;
  localparam float32_t   FP_NEG_ZERO = 32'h80000000;
  localparam logic [7:0] FP_EXP_MAX  = 8'hFF;

  // Per-lane classification captured at acceptance so stage 2 is a plain mux.
  typedef struct packed {
    logic sign;
    logic zero;
    logic nan;
    logic inf;
    logic expLeShift;
    logic gtClip;
  } lane_class_t;

endpackage

// File: rtl/relu_vec_lane.sv
// One float32 lane: input classification (feeds S1) and the activation mux (feeds S2).
module relu_vec_lane
  import relu_vec_pkg::*;
#(
  parameter float32_t CLIP_VAL = 32'h40C00000
) (
  input  float32_t    laneIn_i,
  input  logic [4:0]  shift_i,
  output lane_class_t class_o,
  input  float32_t    s1Lane_i,
  input  lane_class_t s1Class_i,
  input  act_mode_e   s1Mode_i,
  input  logic [4:0]  s1Shift_i,
  output float32_t    result_o
);

  logic [7:0]  inExp;
  logic [22:0] inMant;

  assign inExp  = laneIn_i[30:23];
  assign inMant = laneIn_i[22:0];

  // gtClip is only consulted for non-negative values, so the sign bit is masked off.
  always_comb begin
    class_o            = '0;
    class_o.sign       = laneIn_i[31];
    class_o.zero       = (inExp == 8'h00) && (inMant == 23'd0);
    class_o.nan        = (inExp == FP_EXP_MAX) && (inMant != 23'd0);
    class_o.inf        = (inExp == FP_EXP_MAX) && (inMant == 23'd0);
    class_o.expLeShift = inExp <= {3'b000, shift_i};
    class_o.gtClip     = {1'b0, laneIn_i[30:0]} > CLIP_VAL;
  end

  always_comb begin
    result_o = s1Lane_i;
    if (s1Class_i.nan) begin
      result_o = FP_QNAN;
    end else begin
      case (s1Mode_i)
        ACT_PASS: result_o = s1Lane_i;
        ACT_RELU: begin
          if (s1Class_i.sign) result_o = FP_POS_ZERO;
        end
        // A zero shift is an exact identity, so the flush-to-minus-zero path is skipped.
        ACT_LEAKY: begin
          if (s1Class_i.sign && !s1Class_i.inf && (s1Shift_i != 5'd0)) begin
            if (s1Class_i.expLeShift) result_o = FP_NEG_ZERO;
            else result_o = {1'b1, s1Lane_i[30:23] - {3'b000, s1Shift_i}, s1Lane_i[22:0]};
          end
        end
        ACT_CLIP: begin
          if (s1Class_i.sign) result_o = FP_POS_ZERO;
          else if (s1Class_i.gtClip) result_o = CLIP_VAL;
        end
        default: result_o = s1Lane_i;
      endcase
    end
  end

endmodule

// File: rtl/relu_vec_pipe.sv
// Two-stage vector activation with valid/ready flow control, tag passthrough
// and a saturating count of negative lanes accepted.
module relu_vec_pipe
  import relu_vec_pkg::*;
#(
  parameter int       WIDTH    = 8,
  parameter int       ID_W     = 8,
  parameter float32_t CLIP_VAL = 32'h40C00000,
  parameter int       CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             cfg_mode,
  input  logic [4:0]             cfg_shift,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0][31:0] in_data,
  input  logic [ID_W-1:0]        in_id,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0][31:0] out_data,
  output logic [ID_W-1:0]        out_id,
  input  logic                   clear_stats,
  output logic [CNT_W-1:0]       neg_count
);

  localparam int POP_W = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                     s1Valid_q;
  logic [WIDTH-1:0][31:0]   s1Data_q;
  lane_class_t [WIDTH-1:0]  s1Class_q;
  act_mode_e                s1Mode_q;
  logic [4:0]               s1Shift_q;
  logic [ID_W-1:0]          s1Id_q;

  logic                     outValid_q;
  logic [WIDTH-1:0][31:0]   outData_q;
  logic [ID_W-1:0]          outId_q;

  logic [CNT_W-1:0]         negCount_q, negCount_d;
  logic [POP_W-1:0]         negLanes;
  logic [SUM_W-1:0]         sumWide;

  lane_class_t [WIDTH-1:0]  laneClass;
  logic [WIDTH-1:0][31:0]   laneResult;
  logic                     adv2, accept;

  assign adv2     = !outValid_q || out_ready;
  assign in_ready = !reset && (!s1Valid_q || adv2);
  assign accept   = in_valid && in_ready;

  for (genvar g = 0; g < WIDTH; g++) begin : gLane
    relu_vec_lane #(.CLIP_VAL(CLIP_VAL)) uLane (
      .laneIn_i (in_data[g]),
      .shift_i  (cfg_shift),
      .class_o  (laneClass[g]),
      .s1Lane_i (s1Data_q[g]),
      .s1Class_i(s1Class_q[g]),
      .s1Mode_i (s1Mode_q),
      .s1Shift_i(s1Shift_q),
      .result_o (laneResult[g])
    );
  end

  // in_ready high means S1 is empty or draining, so it may take whatever is offered.
  always_ff @(posedge clk) begin
    if (reset) s1Valid_q <= 1'b0;
    else if (in_ready) s1Valid_q <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1Data_q  <= in_data;
      s1Class_q <= laneClass;
      s1Mode_q  <= act_mode_e'(cfg_mode);
      s1Shift_q <= cfg_shift;
      s1Id_q    <= in_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outId_q    <= '0;
    end else if (adv2) begin
      outValid_q <= s1Valid_q;
      if (s1Valid_q) begin
        outData_q <= laneResult;
        outId_q   <= s1Id_q;
      end
    end
  end

  always_comb begin
    negLanes = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (laneClass[i].sign && !laneClass[i].nan && !laneClass[i].zero)
        negLanes = negLanes + POP_W'(1);
    end
  end

  // The adder is one bit wider than either operand so overflow is visible before clamping.
  always_comb begin
    sumWide    = SUM_W'(negCount_q) + SUM_W'(negLanes);
    negCount_d = negCount_q;
    if (clear_stats) negCount_d = '0;
    else if (accept) negCount_d = (sumWide > SUM_W'(CNT_MAX)) ? CNT_MAX : sumWide[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) negCount_q <= '0;
    else negCount_q <= negCount_d;
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_id    = outId_q;
  assign neg_count = negCount_q;

endmodule

// File: tb/tb_relu_vec_pipe.sv
// Scenario bench for relu_vec_pipe: scoreboard of expected beats plus per-scenario checks.
module tb_relu_vec_pipe;

  typedef logic [7:0][31:0] vec_t;
  typedef struct {
    logic [7:0] id;
    vec_t       data;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] cfg_mode;
  logic [4:0] cfg_shift;
  logic       in_valid;
  logic       in_ready;
  vec_t       in_data;
  logic [7:0] in_id;
  logic       out_valid;
  logic       out_ready;
  vec_t       out_data;
  logic [7:0] out_id;
  logic       clear_stats;
  logic [3:0] neg_count;

  int   checks   = 0;
  int   failures = 0;
  sb_t  sbQ[$];
  int   occ = 0;
  vec_t drvExp;
  logic prevStall = 1'b0;
  vec_t prevData;
  logic [7:0] prevId;

  logic bpEn = 1'b0;
  int   bpIdx = 0;
  bit   bpPat [7] = '{1, 0, 0, 1, 0, 1, 1};

  relu_vec_pipe #(.WIDTH(8), .ID_W(8), .CLIP_VAL(32'h40C00000), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_mode   (cfg_mode),
    .cfg_shift  (cfg_shift),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_id      (in_id),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .clear_stats(clear_stats),
    .neg_count  (neg_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  always @(posedge clk) begin
    if (bpEn) begin
      #1;
      out_ready = (bpIdx < 7) ? bpPat[bpIdx] : 1'b1;
      bpIdx++;
    end
  end

  function automatic vec_t mkVec(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
    vec_t v;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    v[4] = a4; v[5] = a5; v[6] = a6; v[7] = a7;
    return v;
  endfunction

  function automatic logic [31:0] modelLane(input logic [31:0] x, input logic [1:0] mode,
                                            input logic [4:0] sh);
    logic [7:0]  e;
    logic [31:0] r;
    e = x[30:23];
    if (e == 8'hFF && x[22:0] != 0) return 32'h7FC00000;
    case (mode)
      2'd0: return x;
      2'd1: return x[31] ? 32'h0 : x;
      2'd2: begin
        if (!x[31] || sh == 0 || x == 32'hFF800000) return x;
        if (e <= {3'b000, sh}) return 32'h80000000;
        return {1'b1, e - {3'b000, sh}, x[22:0]};
      end
      default: begin
        r = x[31] ? 32'h0 : x;
        return (r > 32'h40C00000) ? 32'h40C00000 : r;
      end
    endcase
  endfunction

  // Scoreboard and flow-control checker, sampled mid-cycle ahead of the next edge.
  always @(negedge clk) begin
    sb_t item;
    logic expReady;
    if (reset) begin
      sbQ.delete();
      occ = 0;
      prevStall = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL in_ready_in_reset got=%b exp=0", in_ready);
      end
    end else begin
      expReady = !(occ == 2 && !out_ready);
      checks++;
      if (in_ready !== expReady) begin
        failures++;
        $display("[TB] FAIL in_ready got=%b exp=%b occ=%0d", in_ready, expReady, occ);
      end
      if (prevStall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prevData || out_id !== prevId) begin
          failures++;
          $display("[TB] FAIL stall_hold got=%b/%h/%h exp=1/%h/%h",
                   out_valid, out_id, out_data, prevId, prevData);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (sbQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_beat got=id %h exp=no beat", out_id);
        end else begin
          item = sbQ.pop_front();
          occ--;
          if (out_id !== item.id || out_data !== item.data) begin
            failures++;
            $display("[TB] FAIL beat got=%h/%h exp=%h/%h", out_id, out_data, item.id, item.data);
          end
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        item.id   = in_id;
        item.data = drvExp;
        sbQ.push_back(item);
        occ++;
      end
      prevStall = (out_valid === 1'b1) && !out_ready;
      prevData  = out_data;
      prevId    = out_id;
    end
  end

  task automatic syncDrive();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t d, input logic [7:0] id, input vec_t e,
                               input logic [1:0] mode, input logic [4:0] sh);
    logic accepted;
    in_data   = d;
    in_id     = id;
    drvExp    = e;
    cfg_mode  = mode;
    cfg_shift = sh;
    in_valid  = 1'b1;
    accepted  = 1'b0;
    for (int n = 0; n < 100 && !accepted; n++) begin
      @(negedge clk);
      accepted = in_ready;
      syncDrive();
    end
    in_valid = 1'b0;
    if (!accepted) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout got=not accepted exp=accepted id=%h", id);
    end
  endtask

  task automatic waitDrain();
    for (int n = 0; n < 100 && (sbQ.size() != 0 || occ != 0); n++) syncDrive();
    checks++;
    if (sbQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain got=%0d pending exp=0", sbQ.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_id !== 8'h00 || neg_count !== 4'd0) begin
      failures++;
      $display("[TB] FAIL reset_state got=%b/%h/%h/%0d exp=0/0/0/0",
               out_valid, out_id, out_data, neg_count);
    end
    syncDrive();
    reset = 1'b0;
  endtask

  task automatic test_relu();
    out_ready = 1'b1;
    applyStimulus(mkVec(32'h3F800000, 32'hBF800000, 32'h80000000, 32'h7F800000,
                        32'hFF800000, 32'h7FA00000, 32'h00000001, 32'h80000001), 8'h10,
                  mkVec(32'h3F800000, 32'h0, 32'h0, 32'h7F800000,
                        32'h0, 32'h7FC00000, 32'h00000001, 32'h0), 2'd1, 5'd0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL relu_latency_early got=%b exp=0", out_valid);
    end
    checks++;
    if (neg_count !== 4'd3) begin
      failures++;
      $display("[TB] FAIL relu_neg_count got=%0d exp=3", neg_count);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_id !== 8'h10) begin
      failures++;
      $display("[TB] FAIL relu_latency got=%b/%h exp=1/10", out_valid, out_id);
    end
    syncDrive();
    waitDrain();
  endtask

  task automatic test_leaky();
    applyStimulus(mkVec(32'hC1000000, 32'h81000000, 32'hFF800000, 32'h40400000,
                        32'h80000000, 32'h80000001, 32'hBF800000, 32'h7FC00001), 8'h20,
                  mkVec(32'hBF800000, 32'h80000000, 32'hFF800000, 32'h40400000,
                        32'h80000000, 32'h80000000, 32'hBE000000, 32'h7FC00000), 2'd2, 5'd3);
    applyStimulus(mkVec(32'hC1000000, 32'h81000000, 32'hFF800000, 32'h3F800000,
                        32'h80000000, 32'hBF800000, 32'h00400000, 32'hC2C80000), 8'h21,
                  mkVec(32'hC1000000, 32'h81000000, 32'hFF800000, 32'h3F800000,
                        32'h80000000, 32'hBF800000, 32'h00400000, 32'hC2C80000), 2'd2, 5'd0);
    waitDrain();
  endtask

  task automatic test_clip();
    applyStimulus(mkVec(32'h40E00000, 32'h40A00000, 32'h7F800000, 32'hC0000000,
                        32'h40C00000, 32'hFF800000, 32'h7FC00000, 32'h00000000), 8'h30,
                  mkVec(32'h40C00000, 32'h40A00000, 32'h40C00000, 32'h0,
                        32'h40C00000, 32'h0, 32'h7FC00000, 32'h0), 2'd3, 5'd7);
    waitDrain();
  endtask

  task automatic test_back_to_back();
    vec_t d, e;
    logic [1:0] m;
    logic [4:0] s;
    bpIdx = 0;
    bpEn  = 1'b1;
    for (int b = 1; b <= 6; b++) begin
      m = 2'($urandom_range(0, 3));
      s = 5'($urandom_range(0, 31));
      for (int l = 0; l < 8; l++) begin
        d[l] = $urandom();
        e[l] = modelLane(d[l], m, s);
      end
      applyStimulus(d, 8'(b), e, m, s);
    end
    waitDrain();
    bpEn = 1'b0;
    syncDrive();
    out_ready = 1'b1;
  endtask

  task automatic test_counter();
    vec_t negs;
    negs = mkVec(32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000,
                 32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000);
    clear_stats = 1'b1;
    syncDrive();
    clear_stats = 1'b0;
    @(negedge clk);
    checks++;
    if (neg_count !== 4'd0) begin
      failures++;
      $display("[TB] FAIL cnt_clear_idle got=%0d exp=0", neg_count);
    end
    syncDrive();
    applyStimulus(negs, 8'h40, '0, 2'd1, 5'd0);
    @(negedge clk);
    checks++;
    if (neg_count !== 4'd8) begin
      failures++;
      $display("[TB] FAIL cnt_first got=%0d exp=8", neg_count);
    end
    syncDrive();
    applyStimulus(negs, 8'h41, '0, 2'd1, 5'd0);
    @(negedge clk);
    checks++;
    if (neg_count !== 4'd15) begin
      failures++;
      $display("[TB] FAIL cnt_saturate got=%0d exp=15", neg_count);
    end
    syncDrive();
    applyStimulus(negs, 8'h42, '0, 2'd1, 5'd0);
    @(negedge clk);
    checks++;
    if (neg_count !== 4'd15) begin
      failures++;
      $display("[TB] FAIL cnt_hold_sat got=%0d exp=15", neg_count);
    end
    syncDrive();
    waitDrain();
    clear_stats = 1'b1;
    applyStimulus(negs, 8'h43, '0, 2'd1, 5'd0);
    clear_stats = 1'b0;
    @(negedge clk);
    checks++;
    if (neg_count !== 4'd0) begin
      failures++;
      $display("[TB] FAIL cnt_clear_priority got=%0d exp=0", neg_count);
    end
    syncDrive();
    applyStimulus(mkVec(32'hBF800000, 32'hFF800000, 32'h80000001, 32'hC0000000,
                        32'h80000000, 32'hFFC00000, 32'h3F800000, 32'h00000000), 8'h44,
                  mkVec(32'hBF800000, 32'hFF800000, 32'h80000001, 32'hC0000000,
                        32'h80000000, 32'h7FC00000, 32'h3F800000, 32'h00000000), 2'd0, 5'd0);
    @(negedge clk);
    checks++;
    if (neg_count !== 4'd4) begin
      failures++;
      $display("[TB] FAIL cnt_mixed_pass got=%0d exp=4", neg_count);
    end
    syncDrive();
    waitDrain();
  endtask

  task automatic test_reset_midstream();
    vec_t d;
    d = mkVec(32'h40E00000, 32'hC0000000, 32'h3F800000, 32'hBF800000,
              32'h7F800000, 32'h40A00000, 32'h00000000, 32'hFF800000);
    out_ready = 1'b0;
    applyStimulus(d, 8'h21, '0, 2'd1, 5'd0);
    applyStimulus(d, 8'h22, '0, 2'd1, 5'd0);
    reset = 1'b1;
    syncDrive();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || neg_count !== 4'd0) begin
      failures++;
      $display("[TB] FAIL midstream_reset got=%b/%0d exp=0/0", out_valid, neg_count);
    end
    syncDrive();
    out_ready = 1'b1;
    applyStimulus(d, 8'h77, mkVec(32'h40C00000, 32'h0, 32'h3F800000, 32'h0,
                                  32'h40C00000, 32'h40A00000, 32'h0, 32'h0), 2'd3, 5'd0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL post_reset_early got=%b exp=0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_id !== 8'h77) begin
      failures++;
      $display("[TB] FAIL post_reset_beat got=%b/%h exp=1/77", out_valid, out_id);
    end
    syncDrive();
    waitDrain();
  endtask

  initial begin
    reset       = 1'b1;
    cfg_mode    = 2'd0;
    cfg_shift   = 5'd0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_id       = 8'h00;
    out_ready   = 1'b1;
    clear_stats = 1'b0;
    drvExp      = '0;
    test_reset();
    test_relu();
    test_leaky();
    test_clip();
    test_back_to_back();
    test_counter();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/relu_vec_pipe.md
Name: relu_vec_pipe

Overview:
- Parametrised successor to the team's vector ReLU stage. Applies a selectable activation to WIDTH IEEE-754 single-precision lanes per beat: pass, ReLU, leaky ReLU with power-of-two slope, or clipped ReLU.
- Sits between a conv/FC accumulator output and the next layer's input buffer.
- Adds valid/ready backpressure, a 2-stage pipeline with a beat-tag passthrough, and a saturating negative-element statistics counter.

Parameters:
- WIDTH, 8, number of 32-bit float lanes per beat.
- ID_W, 8, width of the beat tag carried alongside the data.
- CLIP_VAL, 32'h40C00000, clip ceiling for mode 3 (6.0). Must be positive and finite.
- CNT_W, 32, width of the negative-element counter.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_mode  in  2  activation select: 0 PASS, 1 RELU, 2 LEAKY, 3 CLIP. Sampled on input acceptance.
- cfg_shift  in  5  leaky slope is 2^-cfg_shift. Sampled on input acceptance.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  WIDTH x 32  input lanes.
- in_id  in  ID_W  beat tag.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH x 32  result lanes.
- out_id  out  ID_W  tag of the output beat.
- clear_stats  in  1  synchronous clear of neg_count.
- neg_count  out  CNT_W  saturating count of negative lanes accepted.

Behaviour:
- Reset: all valid flags 0, in_ready 0 during reset, out_valid 0, out_data 0, out_id 0, neg_count 0. Reset mid-stream discards every in-flight beat; the first post-reset beat must be a fresh input.
- Handshake: a beat transfers when valid && ready. in_valid, in_data, in_id and the cfg inputs are held stable by the source until accepted. out_* are held stable while out_valid && !out_ready.
- Pipeline: stage S1 registers lanes, per-lane class flags (sign, zero, NaN, inf, exponent<=shift, >CLIP_VAL) and the sampled cfg. Stage S2 (the output register) holds results.
  - adv2 = !out_valid || out_ready
  - in_ready = !s1_valid || adv2
- Timing and throughput:
  - Latency is 2 cycles from acceptance to out_valid with no stall.
  - Throughput is 1 beat/cycle under continuous out_ready.
  - No beat is lost or duplicated under any out_ready pattern.
- Lane function, with x = lane bits:
  - NaN (exp=FF, mant!=0): output 32'h7FC00000 in every mode.
  - PASS: output x.
  - RELU: if sign=1 (including -0, -inf, denormals), output 32'h00000000; else x.
  - LEAKY: if sign=0, output x. If sign=1:
    - -inf stays -inf.
    - If exp <= cfg_shift (includes -0 and denormals), output 32'h80000000.
    - Else output {1, exp-cfg_shift, mant}.
    - cfg_shift=0 gives identity.
  - CLIP: apply RELU first. If the result is greater than CLIP_VAL (unsigned compare of bits, valid because both are non-negative), output CLIP_VAL. +inf outputs CLIP_VAL.
- Statistics counter:
  - On each accepted input beat, neg_count += number of lanes with sign=1, non-NaN and non-zero.
  - Counting is mode-independent.
  - Saturates at all-ones and never wraps.
  - clear_stats takes priority: the counter becomes 0 and an acceptance in the same cycle is not counted.
- out_id equals the in_id of the same beat; tags travel through the pipeline with the data.

Decomposition:
- Package relu_vec_pkg holds:
  - typedef float32_t (32-bit)
  - mode enum act_mode_e {ACT_PASS, ACT_RELU, ACT_LEAKY, ACT_CLIP}
  - constants FP_QNAN=32'h7FC00000, FP_POS_ZERO, FP_NEG_ZERO, FP_EXP_MAX=8'hFF
- One sub-module, relu_vec_lane: S1 classification plus S2 result mux for one lane, combinational between the parent's registers, instantiated WIDTH times in a generate loop.
- Parent relu_vec_pipe owns the handshake, valid/id/cfg registers, and the popcount/saturating counter.

Test Plan:
- RELU, lanes {3F800000, BF800000, 80000000, 7F800000, FF800000, 7FA00000, 00000001, 80000001}, out_ready=1 -> after 2 cycles out {3F800000, 0, 0, 7F800000, 0, 7FC00000, 00000001, 0}; neg_count=3.
- LEAKY cfg_shift=3, lane C1000000 (-8.0) -> BF800000 (-1.0); lane 81000000 (exp 2<=3) -> 80000000; FF800000 -> FF800000; cfg_shift=0 leaves all lanes unchanged.
- CLIP, lanes 40E00000 (7.0) -> 40C00000; 40A00000 (5.0) -> 40A00000; 7F800000 -> 40C00000; C0000000 -> 0.
- Backpressure: 6 beats id 1..6 back-to-back with out_ready pattern 1,0,0,1,0,1,1,... -> out_id sequence exactly 1..6, data unchanged while stalled, in_ready low only when both stages are full and out_ready=0.
- Counter: preload by streaming all-negative beats (WIDTH=8) with CNT_W=4 -> saturates at 15. clear_stats asserted together with an accepted all-negative beat -> neg_count=0 next cycle.
- Reset asserted while 2 beats are in flight -> out_valid=0 the next cycle, neg_count=0. The beat accepted after reset deasserts emerges with its own id 2 cycles later.
